rom_dl_bridge: RTL
==================

# rom_dl_bridge

Buffers ROM-download bytes from `data_io` and issues them as SDRAM port-1 write transactions using the toggle req/ack protocol. Sits between `data_io` and `sdram` in each core top-level, replacing ad-hoc edge-detect/toggle logic. Adds a small FIFO so back-to-back `ioctl_wr` strobes are never lost while SDRAM is busy. Generates the `rom_loaded` flag used by the top-level reset logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ioctl_download`  in  1  download active, from `data_io`.
- `ioctl_wr`  in  1  byte strobe; level, edge-detected here.
- `ioctl_addr`  in  25  byte address of the current byte.
- `ioctl_dout`  in  8  byte data.
- `port1_req`  out  1  SDRAM request toggle.
- `port1_ack`  in  1  SDRAM ack toggle; transaction done when `port1_ack == port1_req`.
- `port1_a`  out  23  word address, `ioctl_addr[23:1]` of the entry.
- `port1_ds`  out  2  byte enables, `{addr[0], ~addr[0]}`.
- `port1_d`  out  16  `{byte, byte}`.
- `port1_we`  out  1  high while a write is outstanding.
- `busy`  out  1  FIFO non-empty or transaction outstanding.
- `overflow`  out  1  sticky: a byte was dropped.
- `rom_loaded`  out  1  download completed and fully written.

## Operation
- Edge detect: register `wr_last <= ioctl_wr`. Push is requested when `ioctl_download & ioctl_wr & ~wr_last`. Strobes with download low are ignored.
- FIFO entry: `{ioctl_addr[23:0], ioctl_dout}`, 32 bits.
  - Pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
  - `count` is 0..DEPTH.
- Push policy:
  - Push is accepted if `count < DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow <= 1`.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head, load `port1_a/ds/d`, set `port1_we <= 1`, toggle `port1_req`, go to WAIT.
  - WAIT: when `port1_ack == port1_req`, set `port1_we <= 0` and go to IDLE. No pop occurs in WAIT.
- Simultaneous push and pop: both happen and `count` is unchanged. Push with `count == 0` while IDLE is not bypassed; the entry is popped the next cycle.
- `busy = (count != 0) | (state == WAIT)`, registered.
- Download tracking:
  - A rising edge of `ioctl_download` clears `rom_loaded` and `overflow` and sets internal `dl_seen`.
  - `rom_loaded <= 1` when `~ioctl_download & dl_seen & count==0 & state==IDLE`. It then stays 1 until the next download starts.
- Reset (`reset_n == 0` at a clock edge) clears everything: FIFO pointers, count, state to IDLE, `wr_last`, `dl_seen`, and all outputs to 0. This includes `port1_req`, so SDRAM must be reset together or already have `port1_ack` equal to 0. Any reset mid-download discards buffered bytes.
- `port1_ack` changing while in IDLE is ignored.

## Timing
- Strobe to request: `ioctl_wr` first sampled high at edge N → pushed at N. `port1_req` toggles at N+1 if IDLE and FIFO was empty (2-cycle latency as seen on the output).
- Request to next request: at least 1 cycle after ack match. The ack match is seen at edge M, the state is IDLE after M, and the next toggle happens at M+1.
- Throughput is limited by SDRAM ack latency. The FIFO absorbs up to DEPTH strobes during a stall.
- `rom_loaded` rises 1 cycle after the last conditions are all true. It is never asserted while `busy`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single byte: download=1, strobe addr 0x00003 data 0xA5, ack echoes req 3 cycles later. Expect:
  - `port1_req` toggles 2 cycles after the strobe.
  - `port1_a=0x000001`, `ds=2'b10`, `d=0xA5A5`, `we=1` until the ack match.
- Burst with slow SDRAM: DEPTH=4, 4 strobes 2 cycles apart, ack latency 10 cycles. Expect:
  - All 4 writes issued in address order.
  - `overflow=0` throughout.
  - `busy` deasserts after the last ack.
- Overflow: 6 strobes with ack held off. Expect:
  - `overflow=1` after the 6th strobe.
  - Exactly 5 writes issued: 1 in flight plus 4 buffered.
  - The next download start clears `overflow`.
- Completion: download falls while 2 entries are pending. Expect `rom_loaded` stays 0 until the last ack, then rises 1 cycle later.
- Strobe outside download: `ioctl_wr` pulses with download=0. Expect no push, no `req` toggle, `busy=0`.
- Mid-operation reset: assert `reset_n=0` for 1 cycle while in WAIT with 3 queued. Expect:
  - All outputs are 0 the next cycle.
  - No further toggles.
  - `rom_loaded=0`.

Source files
------------

// File: rtl/rom_dl_bridge.sv
// ROM download bridge: queues data_io byte strobes in a small FIFO and replays
// them as SDRAM port-1 toggle req/ack writes, tracking download completion.
module rom_dl_bridge #(
  parameter int DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_last_q, wr_last_d;
  logic          dl_last_q, dl_last_d;
  logic          dl_seen_q, dl_seen_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          rom_loaded_q, rom_loaded_d;
  logic [22:0]   a_q, a_d;
  logic [1:0]    ds_q, ds_d;
  logic [15:0]   d_q, d_d;

  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          dl_rise;
  logic [31:0]   head;
  logic          unused_addr_msb;

  assign unused_addr_msb = ioctl_addr[24];

  always_comb begin
    wr_last_d = ioctl_wr;
    dl_last_d = ioctl_download;
    push_req  = ioctl_download & ioctl_wr & ~wr_last_q;
    dl_rise   = ioctl_download & ~dl_last_q;
    // Pop decision uses registered count, so a push into an empty FIFO is popped next cycle.
    pop       = (state_q == ST_IDLE) && (count_q != '0);
    push_ok   = push_req && ((count_q != FULL) || pop);
    head      = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {ioctl_addr[23:0], ioctl_dout};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          a_d     = head[31:9];
          ds_d    = {head[8], ~head[8]};
          d_d     = {head[7:0], head[7:0]};
          we_d    = 1'b1;
          req_d   = ~req_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (port1_ack == req_q) begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dl_seen_d    = dl_seen_q | dl_rise;
    overflow_d   = overflow_q;
    rom_loaded_d = rom_loaded_q;

    if (dl_rise) begin
      overflow_d   = 1'b0;
      rom_loaded_d = 1'b0;
    end else if (!ioctl_download && dl_seen_q && (count_q == '0) && (state_q == ST_IDLE)) begin
      rom_loaded_d = 1'b1;
    end
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end

    busy_d = (count_d != '0) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_last_q    <= 1'b0;
      dl_last_q    <= 1'b0;
      dl_seen_q    <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      a_q          <= '0;
      ds_q         <= '0;
      d_q          <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_last_q    <= wr_last_d;
      dl_last_q    <= dl_last_d;
      dl_seen_q    <= dl_seen_d;
      req_q        <= req_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      rom_loaded_q <= rom_loaded_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      d_q          <= d_d;
    end
  end

  // Storage needs no reset; entries are only read once the pointers say they are valid.
  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

  assign port1_req  = req_q;
  assign port1_we   = we_q;
  assign port1_a    = a_q;
  assign port1_ds   = ds_q;
  assign port1_d    = d_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;

endmodule
